// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer: operation codes,
// FSM states and the divide-by-zero quotient fill.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Divide by zero: every quotient bit is forced to this value; HI keeps the raw dividend.
  localparam logic DIV0_QUO_FILL = 1'b1;

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mod_muldiv_ctrl_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
// master = pipeline side, slave = sequencer side.
interface mod_muldiv_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mod_muldiv_step.sv
// One combinational radix-2 iteration: multiply add-then-shift-right, or restoring
// divide shift-left then compare/subtract. acc is the product high half / remainder.
module mod_muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] work_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] work_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             rem_ge;

  always_comb begin
    sum    = {1'b0, acc_i} + (work_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {acc_i, work_i[WIDTH-1]};
    rem_ge = (rem_sh >= {1'b0, opnd_i});
    // When rem_ge holds the true difference fits in WIDTH bits.
    diff   = rem_sh[WIDTH-1:0] - opnd_i;
    acc_o  = '0;
    work_o = '0;
    if (is_div_i) begin
      if (rem_ge) begin
        acc_o  = diff;
        work_o = {work_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o  = rem_sh[WIDTH-1:0];
        work_o = {work_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o  = sum[WIDTH:1];
      work_o = {sum[0], work_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mod_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Optional build macro
// MULDIV_EARLY_OUT_EN lets multiplies leave CALC once the remaining multiplier bits are zero.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO honoured
// CALC    | one shift-add / compare-subtract step per cycle
// FIX     | sign correction; HI/LO loaded on exit
// DONE    | one-cycle done pulse; MTHI/MTLO honoured
module mod_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mod_muldiv_ctrl_if.slave      bus
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] mrem_q, mrem_d;
`endif

  md_op_e           op_in;
  logic             op_signed, a_neg, b_neg, busy, calc_exit;
  logic [WIDTH-1:0] a_mag, b_mag, acc_step, work_step;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_al, prod_fix;

  mod_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .work_i   (work_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step),
    .work_o   (work_step)
  );

  always_comb begin
    op_in     = md_op_e'(bus.op);
    op_signed = md_is_signed(op_in);
    a_neg     = op_signed & bus.a[WIDTH-1];
    b_neg     = op_signed & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
  end

  // Result shaping; with early-out the product still owes the skipped right shifts.
  always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
    prod_al   = {acc_q, work_q} >> (LAST_STEP - cnt_q);
    calc_exit = (cnt_q == LAST_STEP) || (!is_div_q && ((mrem_q >> 1) == '0));
`else
    prod_al   = {acc_q, work_q};
    calc_exit = (cnt_q == LAST_STEP);
`endif
    prod_fix = neg_res_q ? -prod_al : prod_al;
    quo_fix  = div0_q ? {WIDTH{DIV0_QUO_FILL}} : (neg_res_q ? -work_q : work_q);
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
`ifdef MULDIV_EARLY_OUT_EN
    mrem_d    = mrem_q;
`endif

    if (!busy) begin
      if (bus.hi_we) hi_d = bus.wdata;
      if (bus.lo_we) lo_d = bus.wdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          state_d   = ST_CALC;
          cnt_d     = '0;
          acc_d     = '0;
          is_div_d  = md_is_div(op_in);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = md_is_div(op_in) && (bus.b == '0);
          work_d    = md_is_div(op_in) ? a_mag : b_mag;
          opnd_d    = md_is_div(op_in) ? b_mag : a_mag;
`ifdef MULDIV_EARLY_OUT_EN
          mrem_d    = b_mag;
`endif
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = acc_step;
          work_d = work_step;
`ifdef MULDIV_EARLY_OUT_EN
          mrem_d = mrem_q >> 1;
`endif
          if (calc_exit) state_d = ST_FIX;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_FIX: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          hi_d    = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_d    = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      work_q    <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      mrem_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
`ifdef MULDIV_EARLY_OUT_EN
      mrem_q    <= mrem_d;
`endif
    end
  end

  assign bus.busy = busy;
  assign bus.done = (state_q == ST_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mod_muldiv_ctrl.sv
// Directed bench for mod_muldiv_ctrl: hand-computed products, quotients, latencies,
// flush, MTHI/MTLO gating and async reset.
module tb_mod_muldiv_ctrl;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_FULL = 34, LAT_5X3 = 4, LAT_X0 = 3, LAT_2X = 4, LAT_6X7 = 5;
`else
  localparam int LAT_FULL = 34, LAT_5X3 = 34, LAT_X0 = 34, LAT_2X = 34, LAT_6X7 = 34;
`endif

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;
  int   lat, bcnt, dcnt;

  mod_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  mod_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input md_op_e o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    tick();
    bus.start = 1'b0;
  endtask

  // Called in the first cycle after the accept edge; returns cycles from the start cycle.
  task automatic wait_done(output int l, output int bc);
    l  = 1;
    bc = 0;
    while (bus.done !== 1'b1 && l < 100) begin
      if (bus.busy === 1'b1) bc++;
      tick();
      l++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi",   64'(bus.hi), 64'd0);
    chk("rst_lo",   64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    tick();

    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    chk("multu_max_lat",  64'(lat), 64'(LAT_FULL));
    chk("multu_max_busy", 64'(bcnt), 64'd33);
    chk("multu_max_hi",   64'(bus.hi), 64'hFFFF_FFFE);
    chk("multu_max_lo",   64'(bus.lo), 64'h0000_0001);
    chk("done_busy_low",  64'(bus.busy), 64'd0);
    tick();
    chk("done_one_cycle", 64'(bus.done), 64'd0);

    launch(MD_MULT, 32'hFFFF_FFF9, 32'd3);
    wait_done(lat, bcnt);
    chk("mult_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mult_neg_lo", 64'(bus.lo), 64'hFFFF_FFEB);
    tick();

    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bcnt);
    chk("div_neg_lat", 64'(lat), 64'(LAT_FULL));
    chk("div_neg_lo",  64'(bus.lo), 64'hFFFF_FFFD);
    chk("div_neg_hi",  64'(bus.hi), 64'hFFFF_FFFF);
    tick();

    launch(MD_DIVU, 32'd100, 32'd0);
    wait_done(lat, bcnt);
    chk("divu_zero_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    chk("divu_zero_hi", 64'(bus.hi), 64'd100);
    tick();

    launch(MD_DIV, 32'hFFFF_FF9C, 32'd0);
    wait_done(lat, bcnt);
    chk("div_zero_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    chk("div_zero_hi", 64'(bus.hi), 64'hFFFF_FF9C);
    tick();

    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    chk("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(bus.hi), 64'd0);
    tick();

    launch(MD_MULTU, 32'd5, 32'd3);
    wait_done(lat, bcnt);
    chk("multu_5x3_lat", 64'(lat), 64'(LAT_5X3));
    chk("multu_5x3_hi",  64'(bus.hi), 64'd0);
    chk("multu_5x3_lo",  64'(bus.lo), 64'd15);
    tick();

    launch(MD_MULTU, 32'h1234_5678, 32'd0);
    wait_done(lat, bcnt);
    chk("multu_x0_lat", 64'(lat), 64'(LAT_X0));
    chk("multu_x0_hi",  64'(bus.hi), 64'd0);
    chk("multu_x0_lo",  64'(bus.lo), 64'd0);
    tick();

    launch(MD_MULTU, 32'h8000_0000, 32'd2);
    wait_done(lat, bcnt);
    chk("multu_2x_lat", 64'(lat), 64'(LAT_2X));
    chk("multu_2x_hi",  64'(bus.hi), 64'd1);
    chk("multu_2x_lo",  64'(bus.lo), 64'd0);
    tick();

    // MTHI/MTLO while idle
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hAAAA_5555;
    tick();
    bus.hi_we = 1'b0;
    bus.wdata = 32'h5555_AAAA;
    tick();
    bus.lo_we = 1'b0;
    chk("mthi_idle", 64'(bus.hi), 64'hAAAA_5555);
    chk("mtlo_idle", 64'(bus.lo), 64'h5555_AAAA);

    // start together with flush in IDLE is dropped
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MD_DIVU; bus.a = 32'd10; bus.b = 32'd3;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("start_flush_idle", 64'(bus.busy), 64'd0);

    // flush in CALC cycle 5
    launch(MD_DIVU, 32'd10, 32'd3);
    tick(); tick(); tick(); tick();
    chk("flush_pre_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_done", 64'(bus.done), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dcnt++;
      tick();
    end
    chk("flush_no_done", 64'(dcnt), 64'd0);
    chk("flush_hi_keep", 64'(bus.hi), 64'hAAAA_5555);
    chk("flush_lo_keep", 64'(bus.lo), 64'h5555_AAAA);

    // MTHI and a second start while busy are ignored
    launch(MD_MULTU, 32'd6, 32'd7);
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    bus.start = 1'b1; bus.op = MD_DIVU; bus.a = 32'd1; bus.b = 32'd1;
    tick();
    bus.hi_we = 1'b0; bus.start = 1'b0;
    chk("mthi_busy_ignored", 64'(bus.hi), 64'hAAAA_5555);
    wait_done(lat, bcnt);
    chk("busy_start_lat", 64'(lat + 1), 64'(LAT_6X7));
    chk("busy_start_hi",  64'(bus.hi), 64'd0);
    chk("busy_start_lo",  64'(bus.lo), 64'd42);
    // MTHI in DONE overwrites the fresh result; start in DONE is ignored
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd9; bus.b = 32'd9;
    tick();
    bus.hi_we = 1'b0; bus.start = 1'b0;
    chk("mthi_done_hi",   64'(bus.hi), 64'h0000_1234);
    chk("mthi_done_lo",   64'(bus.lo), 64'd42);
    chk("start_in_done",  64'(bus.busy), 64'd0);

    // async reset mid-operation
    launch(MD_MULTU, 32'd3, 32'hFFFF_FFFF);
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_hi",   64'(bus.hi), 64'd0);
    chk("arst_lo",   64'(bus.lo), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("arst_idle", 64'(bus.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
